addition_control_unit: RTL
==========================

Name: addition_control_unit

Overview:
- Multi-cycle sequencer for the single-precision FP adder datapath.
- Drives three selects into the operand-select stage: bigger mantissa (mux1), smaller mantissa (mux2) and bigger exponent (mux3).
- Derives the alignment shift amount, strobes the align, add and normalize stage registers, and runs the iterative normalization loop.
- Exposes a start/ready/done handshake to the adder top module.

Parameters:
- MENT_WIDTH, 23, mantissa field width; hidden-bit datapath is MENT_WIDTH+1.
- EXPO_WIDTH, 8, exponent width; exp_diff is EXPO_WIDTH+1 bits.
- SHAMT_WIDTH, 5, alignment/normalize shift-count width; must satisfy 2^SHAMT_WIDTH > MENT_WIDTH+1.

Ports:
- clk_in  input  1  clock; all state updates on the rising edge.
- rst_in  input  1  asynchronous, active-high reset.
- start_in  input  1  operands valid on the stage inputs; accepted only when ready_out=1.
- exp_diff_in  input  EXPO_WIDTH+1  exponent1 + two's complement of exponent2, mod 2^(EXPO_WIDTH+1); bit[EXPO_WIDTH]=1 means exponent1 < exponent2.
- sum_carry_in  input  1  mantissa adder carry-out (overflow).
- sum_msb_in  input  1  hidden-bit position of the current normalized sum.
- sum_zero_in  input  1  current sum is all zero.
- exp_min_in  input  1  current result exponent equals 1; no further decrement is allowed.
- exp_max_in  input  1  current result exponent equals all-ones minus 1.
- ready_out  output  1  controller is idle.
- mux1_sel_out, mux2_sel_out, mux3_sel_out  output  1 each  1 = operand1 is bigger.
- align_shamt_out  output  SHAMT_WIDTH  right-shift amount for the smaller mantissa.
- align_load_out, add_load_out  output  1 each  load strobes for stage 2 and stage 3.
- norm_shr_out, norm_shl_out  output  1 each  one-position normalize shift strobes.
- exp_inc_out, exp_dec_out  output  1 each  result exponent adjust strobes.
- done_out  output  1  result valid; one-cycle pulse.
- overflow_out, zero_out  output  1 each  result flags; valid while done_out=1.

Behaviour:
- Reset, asynchronous: state=IDLE; ready_out=1; all other outputs 0; selects 0; align_shamt_out 0.
- States: IDLE, COMPARE, ALIGN, ADD, NORM, DONE.
- IDLE:
  - ready_out=1.
  - start_in=1 captures exp_diff_in into a register and moves to COMPARE.
  - start_in while busy is ignored; no queueing.
- COMPARE, 1 cycle:
  - If diff[EXPO_WIDTH]=0: all selects=1 and shamt = diff[EXPO_WIDTH-1:0].
  - Otherwise: all selects=0 and shamt = two's complement of the full diff, low EXPO_WIDTH bits.
  - Equal exponents (diff=0): selects=1, shamt=0.
  - Shamt saturates at MENT_WIDTH+1; e.g. diff magnitude 200 gives 24.
  - Selects and shamt are registered and held stable through DONE.
- ALIGN, 1 cycle: align_load_out=1.
- ADD, 1 cycle: add_load_out=1; clear the normalize iteration counter.
- NORM, evaluated each cycle with the priority below:
  1. sum_zero_in → zero_out=1, go to DONE.
  2. sum_carry_in → norm_shr_out=1, exp_inc_out=1; overflow_out=1 if exp_max_in; go to DONE.
  3. sum_msb_in=1 → go to DONE.
  4. exp_min_in=1 → go to DONE, leaving a denormal result.
  5. Otherwise norm_shl_out=1, exp_dec_out=1, counter++. When the counter reaches MENT_WIDTH+1, go to DONE (safety bound).
- DONE, 1 cycle: done_out=1, flags valid, then return to IDLE with flags cleared.
- Latency:
  - Start to done is 5 cycles minimum: COMPARE, ALIGN, ADD, NORM, DONE.
  - Maximum is 4 + (MENT_WIDTH+1) + 1 = 29 cycles.
- All strobes are one-cycle and mutually exclusive across stages.
- Reset mid-operation aborts immediately and returns to IDLE; no done_out is produced.

Optional Feature:
- Macro: ADDCTL_FAR_PATH_BYPASS_EN.
- When defined:
  - In COMPARE, a diff magnitude greater than MENT_WIDTH+1 (the smaller operand is fully shifted out) goes directly to DONE.
  - ALIGN, ADD and NORM are skipped; mux selects remain valid so the top module forwards the bigger operand.
  - Added output bypass_out (1 bit) is asserted together with done_out. Latency is 2 cycles.
- When not defined: no bypass_out port; every operation takes the full path with shamt saturated.

Decomposition:
- Package addition_pkg holds:
  - state enum: IDLE, COMPARE, ALIGN, ADD, NORM, DONE;
  - constants MENT_WIDTH, EXPO_WIDTH, SHAMT_WIDTH, NORM_MAX_ITER = MENT_WIDTH+1.
- One sub-module, addition_exp_compare: combinational; decodes exp_diff into bigger_is_op1, magnitude, saturated shamt and far_path.

Test Plan:
- Reset mid-NORM (rst_in pulsed on the 3rd NORM cycle) → IDLE immediately, ready_out=1, no done_out, all strobes 0.
- exp_diff=9'h005 (e1=130, e2=125) → selects=1, shamt=5, strobe order align/add, sum_msb_in=1 → done_out at cycle 5.
- exp_diff=9'h1FD (e1 < e2 by 3) → selects=0, shamt=3; equal exponents (9'h000) → selects=1, shamt=0.
- sum_carry_in=1 with exp_max_in=1 in NORM → norm_shr_out and exp_inc_out for one cycle, then done_out with overflow_out=1.
- Cancellation case: sum_msb_in goes high after 4 shl cycles → exactly 4 norm_shl_out/exp_dec_out pulses. Variant with exp_min_in asserted after 2 shifts → stop at 2. Variant with sum_zero_in=1 → zero_out=1, no shifts.
- With ADDCTL_FAR_PATH_BYPASS_EN defined: exp_diff=9'h01E (30) → done_out and bypass_out 2 cycles after start, no align/add strobes. Without the macro: same stimulus gives shamt=24 and the full path.

Source files
------------

// File: rtl/addition_pkg.sv
// Shared types and sizing for the FP adder control slice.
package addition_pkg;

  localparam int MENT_WIDTH    = 23;
  localparam int EXPO_WIDTH    = 8;
  localparam int SHAMT_WIDTH   = 5;
  localparam int NORM_MAX_ITER = MENT_WIDTH + 1;

  typedef enum logic [2:0] {
    IDLE,
    COMPARE,
    ALIGN,
    ADD,
    NORM,
    DONE
  } state_t;

endpackage

// File: rtl/addition_exp_compare.sv
// Exponent difference decoder: operand order, magnitude,
// saturated alignment shift and far-path detect.
module addition_exp_compare #(
  parameter int MENT_WIDTH  = 23,
  parameter int EXPO_WIDTH  = 8,
  parameter int SHAMT_WIDTH = 5
) (
  input  logic [EXPO_WIDTH:0]    exp_diff,
  output logic                   bigger_is_op1,
  output logic [SHAMT_WIDTH-1:0] shamt,
  output logic                   far_path
);

  localparam logic [EXPO_WIDTH-1:0] SAT =
    EXPO_WIDTH'(MENT_WIDTH + 1);
  localparam logic [SHAMT_WIDTH-1:0] SAT_SH =
    SHAMT_WIDTH'(MENT_WIDTH + 1);

  logic [EXPO_WIDTH-1:0] neg;
  logic [EXPO_WIDTH-1:0] magnitude;

  always_comb begin
    neg           = -exp_diff[EXPO_WIDTH-1:0];
    bigger_is_op1 = ~exp_diff[EXPO_WIDTH];
    magnitude     = exp_diff[EXPO_WIDTH] ? neg
                  : exp_diff[EXPO_WIDTH-1:0];
    far_path      = magnitude > SAT;
    // below saturation the magnitude fits the shift field
    shamt         = far_path ? SAT_SH
                  : magnitude[SHAMT_WIDTH-1:0];
  end

endmodule

// File: rtl/addition_control_unit.sv
// Multi-cycle sequencer for the FP adder datapath.
// ADDCTL_FAR_PATH_BYPASS_EN adds the far-path bypass and bypass_out.
module addition_control_unit #(
  parameter int MENT_WIDTH  = addition_pkg::MENT_WIDTH,
  parameter int EXPO_WIDTH  = addition_pkg::EXPO_WIDTH,
  parameter int SHAMT_WIDTH = addition_pkg::SHAMT_WIDTH
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  input  logic                   start_in,
  input  logic [EXPO_WIDTH:0]    exp_diff_in,
  input  logic                   sum_carry_in,
  input  logic                   sum_msb_in,
  input  logic                   sum_zero_in,
  input  logic                   exp_min_in,
  input  logic                   exp_max_in,
  output logic                   ready_out,
  output logic                   mux1_sel_out,
  output logic                   mux2_sel_out,
  output logic                   mux3_sel_out,
  output logic [SHAMT_WIDTH-1:0] align_shamt_out,
  output logic                   align_load_out,
  output logic                   add_load_out,
  output logic                   norm_shr_out,
  output logic                   norm_shl_out,
  output logic                   exp_inc_out,
  output logic                   exp_dec_out,
  output logic                   done_out,
  output logic                   overflow_out,
  output logic                   zero_out
`ifdef ADDCTL_FAR_PATH_BYPASS_EN
  ,
  output logic                   bypass_out
`endif
);

  import addition_pkg::*;

`ifdef ADDCTL_FAR_PATH_BYPASS_EN
  localparam bit BYPASS_EN = 1'b1;
`else
  localparam bit BYPASS_EN = 1'b0;
`endif

  localparam logic [SHAMT_WIDTH-1:0] ITER_MAX =
    SHAMT_WIDTH'(MENT_WIDTH + 1);

  state_t                 state;
  logic [EXPO_WIDTH:0]    diff_q;
  logic [SHAMT_WIDTH-1:0] cnt_q;
  logic                   big1;
  logic                   far;
  logic [SHAMT_WIDTH-1:0] shamt;
  logic                   shl_step;

  addition_exp_compare #(
    .MENT_WIDTH  (MENT_WIDTH),
    .EXPO_WIDTH  (EXPO_WIDTH),
    .SHAMT_WIDTH (SHAMT_WIDTH)
  ) u_cmp (
    .exp_diff      (diff_q),
    .bigger_is_op1 (big1),
    .shamt         (shamt),
    .far_path      (far)
  );

  // normalize strobes act on the sum seen this cycle
  always_comb begin
    norm_shr_out = 1'b0;
    exp_inc_out  = 1'b0;
    shl_step     = 1'b0;
    if (state == NORM && !sum_zero_in) begin
      if (sum_carry_in) begin
        norm_shr_out = 1'b1;
        exp_inc_out  = 1'b1;
      end else begin
        shl_step = !sum_msb_in && !exp_min_in
                && (cnt_q != ITER_MAX);
      end
    end
    norm_shl_out = shl_step;
    exp_dec_out  = shl_step;
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state           <= IDLE;
      ready_out       <= 1'b1;
      diff_q          <= '0;
      cnt_q           <= '0;
      mux1_sel_out    <= 1'b0;
      mux2_sel_out    <= 1'b0;
      mux3_sel_out    <= 1'b0;
      align_shamt_out <= '0;
      align_load_out  <= 1'b0;
      add_load_out    <= 1'b0;
      done_out        <= 1'b0;
      overflow_out    <= 1'b0;
      zero_out        <= 1'b0;
    end else begin
      align_load_out <= 1'b0;
      add_load_out   <= 1'b0;
      done_out       <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start_in) begin
            diff_q    <= exp_diff_in;
            ready_out <= 1'b0;
            state     <= COMPARE;
          end
        end
        COMPARE: begin
          mux1_sel_out    <= big1;
          mux2_sel_out    <= big1;
          mux3_sel_out    <= big1;
          align_shamt_out <= shamt;
          if (BYPASS_EN && far) begin
            done_out <= 1'b1;
            state    <= DONE;
          end else begin
            align_load_out <= 1'b1;
            state          <= ALIGN;
          end
        end
        ALIGN: begin
          add_load_out <= 1'b1;
          state        <= ADD;
        end
        ADD: begin
          cnt_q <= '0;
          state <= NORM;
        end
        NORM: begin
          if (shl_step) begin
            cnt_q <= cnt_q + 1'b1;
          end else begin
            zero_out     <= sum_zero_in;
            overflow_out <= !sum_zero_in && sum_carry_in
                         && exp_max_in;
            done_out     <= 1'b1;
            state        <= DONE;
          end
        end
        DONE: begin
          zero_out     <= 1'b0;
          overflow_out <= 1'b0;
          ready_out    <= 1'b1;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ADDCTL_FAR_PATH_BYPASS_EN
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) bypass_out <= 1'b0;
    else        bypass_out <= (state == COMPARE) && far;
  end
`endif

endmodule
